sdram_arb2: RTL

Two-master arbiter in front of the Avalon-MM slave port of the on-chip SDRAM controller (25-bit word address, 16-bit data, active-low byte enables).
- Accepts commands from master 0 (e.g. video fetch) and master 1 (e.g. CPU/DMA).
- Grants the single SDRAM port round-robin and issues one registered command at a time.
- Tracks outstanding reads in an in-order tag FIFO so that each sdram_readdatavalid beat returns to the master that issued it.

---
 rtl/sdram_arb2.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sdram_arb2.sv
// Two-master round-robin arbiter for the SDRAM controller Avalon-MM slave, with in-order read-tag FIFO.
// Define SDRAM_ARB_FIXED_PRIO_EN to give master 0 fixed priority over master 1.
module sdram_arb2 #(
   parameter int unsigned ADDR_W   = 25,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned BE_W     = 2,
   parameter int unsigned MAX_PEND = 8
) (
   input  logic                        clk_clk,
   input  logic                        reset_reset,
   input  logic [ADDR_W-1:0]           m0_address,
   input  logic [BE_W-1:0]             m0_byteenable,
   input  logic                        m0_read,
   input  logic                        m0_write,
   input  logic [DATA_W-1:0]           m0_writedata,
   output logic                        m0_waitrequest,
   output logic [DATA_W-1:0]           m0_readdata,
   output logic                        m0_readdatavalid,
   input  logic [ADDR_W-1:0]           m1_address,
   input  logic [BE_W-1:0]             m1_byteenable,
   input  logic                        m1_read,
   input  logic                        m1_write,
   input  logic [DATA_W-1:0]           m1_writedata,
   output logic                        m1_waitrequest,
   output logic [DATA_W-1:0]           m1_readdata,
   output logic                        m1_readdatavalid,
   output logic [ADDR_W-1:0]           sdram_address,
   output logic [BE_W-1:0]             sdram_byteenable_n,
   output logic                        sdram_chipselect,
   output logic [DATA_W-1:0]           sdram_writedata,
   output logic                        sdram_read_n,
   output logic                        sdram_write_n,
   input  logic [DATA_W-1:0]           sdram_readdata,
   input  logic                        sdram_readdatavalid,
   input  logic                        sdram_waitrequest,
   output logic [$clog2(MAX_PEND):0]   pend_count,
   output logic                        err_underflow
);

   localparam int unsigned PTR_W = $clog2(MAX_PEND);
   localparam int unsigned PC_W  = $clog2(MAX_PEND) + 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be_n;
      logic [DATA_W-1:0] wdata;
      logic              rd;
      logic              tag;
   } cmd_t;

   state_t            state, state_d;
   cmd_t              cmd_q, sel_cmd_c;
   logic              last_grant;
   logic              tag_mem [MAX_PEND];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PC_W-1:0]   fifo_cnt;
   logic              pend_full_c, m0_elig_c, m1_elig_c, sel_m1_c;
   logic              accept_c, consume_c, push_c, pop_c, fifo_empty_c;

   assign pend_full_c  = (pend_count == PC_W'(MAX_PEND));
   assign m0_elig_c    = (m0_read | m0_write) & ~(m0_read & pend_full_c);
   assign m1_elig_c    = (m1_read | m1_write) & ~(m1_read & pend_full_c);
   assign fifo_empty_c = (fifo_cnt == '0);
   assign push_c       = consume_c & cmd_q.rd;
   assign pop_c        = sdram_readdatavalid & ~fifo_empty_c;

   // On a tie the master that did not win last time is picked
`ifdef SDRAM_ARB_FIXED_PRIO_EN
   assign sel_m1_c = m1_elig_c & ~m0_elig_c;
`else
   assign sel_m1_c = m1_elig_c & (~m0_elig_c | ~last_grant);
`endif

   // Next state, grant handshake and command selection
   always_comb begin
      state_d        = state;
      accept_c       = 1'b0;
      consume_c      = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      sel_cmd_c      = '0;
      if (sel_m1_c) begin
         sel_cmd_c.addr  = m1_address;
         sel_cmd_c.be_n  = ~m1_byteenable;
         sel_cmd_c.wdata = m1_writedata;
         sel_cmd_c.rd    = m1_read;
         sel_cmd_c.tag   = 1'b1;
      end else begin
         sel_cmd_c.addr  = m0_address;
         sel_cmd_c.be_n  = ~m0_byteenable;
         sel_cmd_c.wdata = m0_writedata;
         sel_cmd_c.rd    = m0_read;
         sel_cmd_c.tag   = 1'b0;
      end
      case (state)
         IDLE: begin
            if (!reset_reset && (m0_elig_c || m1_elig_c)) begin
               accept_c = 1'b1;
               state_d  = ISSUE;
               if (sel_m1_c) m1_waitrequest = 1'b0;
               else          m0_waitrequest = 1'b0;
            end
         end
         ISSUE: begin
            if (!sdram_waitrequest) begin
               consume_c = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) state <= IDLE;
      else             state <= state_d;
   end

   // Command registers driving the controller port
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         cmd_q            <= '0;
         cmd_q.be_n       <= '1;
         sdram_chipselect <= 1'b0;
         sdram_read_n     <= 1'b1;
         sdram_write_n    <= 1'b1;
         last_grant       <= 1'b1;
      end else if (accept_c) begin
         cmd_q            <= sel_cmd_c;
         sdram_chipselect <= 1'b1;
         sdram_read_n     <= ~sel_cmd_c.rd;
         sdram_write_n    <= sel_cmd_c.rd;
         last_grant       <= sel_cmd_c.tag;
      end else if (consume_c) begin
         sdram_chipselect <= 1'b0;
         sdram_read_n     <= 1'b1;
         sdram_write_n    <= 1'b1;
      end
   end

   assign sdram_address      = cmd_q.addr;
   assign sdram_byteenable_n = cmd_q.be_n;
   assign sdram_writedata    = cmd_q.wdata;

   always_ff @(posedge clk_clk) begin
      if (push_c) tag_mem[wr_ptr] <= cmd_q.tag;
   end

   // Tag FIFO pointers, occupancy, pending count and return path
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         fifo_cnt         <= '0;
         pend_count       <= '0;
         err_underflow    <= 1'b0;
         m0_readdatavalid <= 1'b0;
         m1_readdatavalid <= 1'b0;
         m0_readdata      <= '0;
         m1_readdata      <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_cnt   <= fifo_cnt + PC_W'(push_c) - PC_W'(pop_c);
         pend_count <= pend_count + PC_W'(accept_c & sel_cmd_c.rd) - PC_W'(pop_c);
         if (sdram_readdatavalid && fifo_empty_c) err_underflow <= 1'b1;
         m0_readdatavalid <= pop_c & ~tag_mem[rd_ptr];
         m1_readdatavalid <= pop_c & tag_mem[rd_ptr];
         if (pop_c) begin
            m0_readdata <= sdram_readdata;
            m1_readdata <= sdram_readdata;
         end
      end
   end

endmodule
